// File: rtl/ais_frame_builder.sv
// Bit-serial AIS/HDLC transmit framer: training, start flag, stuffed payload + FCS, end flag.
// Optional NRZI line coding is enabled with `define AIS_FRAME_BUILDER_NRZI_EN.
//
// state   | meaning
// IDLE    | no frame; waits for s_axis_tvalid to start one
// TRAIN   | loading 0,1,0,1,... training bits
// START   | loading the 0x7E start flag
// PAYLOAD | passing payload bits through, updating CRC, inserting stuff bits
// FCS     | loading ~CRC LSB first, inserting stuff bits
// END     | loading the 0x7E end flag; cnt==8 waits for tlast acceptance
module ais_frame_builder #(
   parameter int PAR_PAYLOAD_BITS = 168,
   parameter int PAR_TRAIN_BITS   = 24
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic s_axis_tvalid,
   output logic s_axis_tready,
   input  logic s_axis_tdata,
   output logic m_axis_tvalid,
   input  logic m_axis_tready,
   output logic m_axis_tdata,
   output logic m_axis_tlast,
   output logic o_busy
);

   typedef enum logic [2:0] {IDLE, TRAIN, START, PAYLOAD, FCS, END} state_t;

   localparam logic [7:0]  FLAG       = 8'h7E;
   localparam logic [15:0] CRC_POLY   = 16'h8408;
   localparam logic [15:0] TRAIN_LAST = 16'(PAR_TRAIN_BITS - 1);
   localparam logic [15:0] PAY_LAST   = 16'(PAR_PAYLOAD_BITS - 1);

   state_t      state;
   logic [15:0] cnt;
   logic [15:0] crc;
   logic [2:0]  ones;
   logic        stuff_due;

   logic        advance;
   logic        emit;
   logic        raw;
   logic        line_bit;
   logic        stuff_hit;
   logic [2:0]  ones_next;
   logic [15:0] crc_next;

`ifdef AIS_FRAME_BUILDER_NRZI_EN
   logic level;
`endif

   // raw is the unencoded bit that the output register loads when emit is high
   always_comb begin
      advance = ~m_axis_tvalid | m_axis_tready;
      emit    = 1'b0;
      raw     = 1'b0;
      case (state)
         IDLE:    emit = s_axis_tvalid;
         TRAIN:   begin emit = advance; raw = cnt[0]; end
         START:   begin emit = advance; raw = FLAG[cnt[2:0]]; end
         PAYLOAD: begin
            emit = advance & (stuff_due | s_axis_tvalid);
            raw  = ~stuff_due & s_axis_tdata;
         end
         FCS:     begin emit = advance; raw = ~stuff_due & ~crc[cnt[3:0]]; end
         END:     begin emit = advance & ~cnt[3]; raw = FLAG[cnt[2:0]]; end
         default: ;
      endcase

      s_axis_tready = (state == PAYLOAD) & ~stuff_due & advance;
      o_busy        = (state != IDLE);

      stuff_hit = raw & (ones == 3'd4);
      ones_next = (raw && !stuff_hit) ? ones + 3'd1 : 3'd0;
      crc_next  = (crc >> 1) ^ ((crc[0] ^ s_axis_tdata) ? CRC_POLY : 16'h0000);

`ifdef AIS_FRAME_BUILDER_NRZI_EN
      // line level restarts at 0 for every frame; a raw 0 toggles it
      line_bit = ((state == IDLE) ? 1'b0 : level) ^ ~raw;
`else
      line_bit = raw;
`endif
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         crc           <= 16'hFFFF;
         ones          <= '0;
         stuff_due     <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= 1'b0;
         m_axis_tlast  <= 1'b0;
`ifdef AIS_FRAME_BUILDER_NRZI_EN
         level         <= 1'b0;
`endif
      end else begin
         if (emit) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= line_bit;
            m_axis_tlast  <= (state == END) && (cnt[2:0] == 3'd7);
`ifdef AIS_FRAME_BUILDER_NRZI_EN
            level         <= line_bit;
`endif
         end else if (advance) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
         end

         case (state)
            IDLE: if (emit) begin
               state <= TRAIN;
               cnt   <= 16'd1;
            end
            TRAIN: if (emit) begin
               if (cnt == TRAIN_LAST) begin
                  state <= START;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            START: if (emit) begin
               if (cnt[2:0] == 3'd7) begin
                  state     <= PAYLOAD;
                  cnt       <= '0;
                  crc       <= 16'hFFFF;
                  ones      <= '0;
                  stuff_due <= 1'b0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            PAYLOAD: if (emit) begin
               if (stuff_due) begin
                  stuff_due <= 1'b0;
               end else begin
                  crc       <= crc_next;
                  ones      <= ones_next;
                  stuff_due <= stuff_hit;
                  if (cnt == PAY_LAST) begin
                     state <= FCS;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
            end
            FCS: if (emit) begin
               // cnt==16 marks a stuff bit still owed after the last FCS bit
               if (stuff_due) begin
                  stuff_due <= 1'b0;
                  if (cnt == 16'd16) begin
                     state <= END;
                     cnt   <= '0;
                  end
               end else begin
                  ones      <= ones_next;
                  stuff_due <= stuff_hit;
                  if (cnt == 16'd15) begin
                     if (stuff_hit) begin
                        cnt <= 16'd16;
                     end else begin
                        state <= END;
                        cnt   <= '0;
                     end
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
            end
            END: if (advance) begin
               if (cnt[3]) begin
                  state         <= IDLE;
                  cnt           <= '0;
                  m_axis_tvalid <= 1'b0;
                  m_axis_tlast  <= 1'b0;
                  m_axis_tdata  <= 1'b0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/ais_frame_builder.md
# ais_frame_builder

Bit-serial AIS/HDLC frame builder. It is the transmit-side counterpart of the frame detector chain. It takes a 168-bit payload as a 1-bit AXI-stream, then emits one complete frame as a 1-bit AXI-stream toward the modulator: training sequence, start flag, payload, CRC-16 FCS, end flag. Bit stuffing applies to payload and FCS, and NRZI encoding is optional.

## Interface
- PAR_PAYLOAD_BITS, 168, payload length in bits per frame
- PAR_TRAIN_BITS, 24, training-sequence length in bits (even)
- i_clk  in  1  system clock, all logic on rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- s_axis_tvalid  in  1  payload bit valid
- s_axis_tready  out  1  payload bit accepted when tvalid&tready
- s_axis_tdata  in  1  payload bit, sent in arrival order
- m_axis_tvalid  out  1  frame bit valid
- m_axis_tready  in  1  downstream accepts bit
- m_axis_tdata  out  1  frame bit (line level when NRZI enabled)
- m_axis_tlast  out  1  high on the last bit of the end flag
- o_busy  out  1  high from leaving IDLE until the tlast bit is accepted

## Operation
- FSM states: IDLE, TRAIN, START, PAYLOAD, FCS, END.
- IDLE -> TRAIN when s_axis_tvalid=1. The pending payload bit is not consumed.
- TRAIN: emits PAR_TRAIN_BITS raw bits 0,1,0,1,…, starting with 0.
- START: emits 0x7E LSB first (0,1,1,1,1,1,1,0).
- PAYLOAD: consumes and emits PAR_PAYLOAD_BITS input bits.
- FCS: emits 16 CRC bits, LSB first.
- END: emits 0x7E LSB first, asserts m_axis_tlast on its 8th bit, then returns to IDLE.
- CRC: CRC-16-CCITT in reflected form (poly 0x8408, right-shift). Init 0xFFFF at entry to PAYLOAD. Updated per accepted payload bit. Transmitted value is ~crc.
- Stuffing: a ones-counter runs on raw bits in PAYLOAD and FCS only, and is cleared on entry to PAYLOAD.
  - After 5 consecutive ones, one 0 is inserted and the counter clears.
  - During an inserted bit, s_axis_tready=0 and the CRC does not update.
  - A stuff due after the last FCS bit is emitted before END.
  - Flags and training are never stuffed and never counted.
- Source underflow in PAYLOAD: m_axis_tvalid deasserts until s_axis_tvalid returns. The frame continues and is not aborted.
- s_axis_tready = (state==PAYLOAD) & ~stuff_due & (~m_axis_tvalid | m_axis_tready). This is combinational from m_axis_tready.
- Output register advances only when ~m_axis_tvalid | m_axis_tready. m_axis_tdata and m_axis_tlast hold stable while tvalid&~tready.

## Timing
- Reset (async, any state): IDLE. m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, s_axis_tready=0, o_busy=0. CRC=0xFFFF, ones-counter=0, NRZI level=0.
- Latency: s_axis_tvalid rising in IDLE at cycle n gives the first training bit on m_axis at n+1.
- An accepted payload bit appears on m_axis the next cycle.
- With m_axis_tready=1 and no underflow, one bit per cycle. Frame length is 224 + stuffed bits for the default parameters.
- Back-to-back frames: IDLE lasts at least one cycle after tlast is accepted.
- Reset mid-frame discards the frame. No partial tlast is emitted.

## Configuration
- AIS_FRAME_BUILDER_NRZI_EN defined: NRZI is applied to the whole frame from the first training bit.
  - The level register is set to 0 on entry to TRAIN.
  - Raw 0 toggles the level, raw 1 holds it.
  - m_axis_tdata is the new level.
- Macro not defined: m_axis_tdata is the raw stuffed bit stream. The level register is absent.

## Test plan
- Alternating 0,1 payload, macro undefined, tready=1 -> bits 0..23 = 0101…, bits 24..31 = 0,1,1,1,1,1,1,0, bits 32..199 equal the payload, FCS equals the reference-model ~CRC, last 8 bits = 0x7E with tlast on the final bit.
- All-ones payload -> 33 zeros inserted in the payload (after every 5th one), s_axis_tready low for exactly those 33 cycles, ones-count 3 carried into FCS, total length checked against model.
- Macro defined, any payload -> first 8 m_axis_tdata = 1,1,0,0,1,1,0,0. Decoding NRZI+destuffing at the bench recovers the payload and a valid CRC.
- Random m_axis_tready (50%) and random s_axis_tvalid gaps in PAYLOAD -> accepted bit stream identical to the uninterrupted run. Data stable while stalled.
- i_rst_n pulsed low during FCS -> same cycle m_axis_tvalid=0, o_busy=0. A following frame is bit-exact with the model (CRC and NRZI reinitialised).
- Two frames back to back with s_axis_tvalid held high -> a second full frame starts after at least 1 IDLE cycle. Each frame has exactly one tlast.
